// File: rtl/sram_2kx8_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sram_2kx8_arbiter_pkg
//   Shared definitions for the two-port arbiter in front of the sram_2kx8
//   single-port block RAM.
//
//   Contents:
//     DEF_ADDR_W / DEF_DATA_W  default geometry of the 2K x 8 memory map
//     port_e                   requester identity (PORT_CPU = 0, PORT_DMA = 1)
//     other_port()             the requester that is not the given one
// ---------------------------------------------------------------------------
package sram_2kx8_arbiter_pkg;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 8;

  // Port 0 is the CPU-side bus bridge, port 1 the DMA/peripheral side.
  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DMA = 1'b1
  } port_e;

  function automatic port_e other_port(input port_e p);
    return (p == PORT_CPU) ? PORT_DMA : PORT_CPU;
  endfunction

endpackage

// File: rtl/sram_2kx8_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// sram_2kx8_arbiter_rr_arb2
//   Two-way grant for the SRAM arbiter. A lone requester always wins. On a
//   conflict the grant goes either to the port that did not win last time
//   (round-robin) or always to port 0 (fixed priority, port 1 may starve).
//
//   Ports:
//     clk         in   clock, state updates on posedge
//     reset       in   asynchronous active-high reset
//     req[1:0]    in   request per port (bit 0 = CPU, bit 1 = DMA)
//     fixed_prio  in   1 = port 0 wins every conflict
//     advance     in   an access was accepted this cycle; record the winner
//     gnt[1:0]    out  one-hot grant, or zero when nobody requests
// ---------------------------------------------------------------------------
module sram_2kx8_arbiter_rr_arb2
  import sram_2kx8_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       fixed_prio,
  input  logic       advance,
  output logic [1:0] gnt
);

  port_e last_grant;
  port_e conflict_winner;

  // Winner of a two-way conflict; a lone requester bypasses this entirely.
  always_comb begin
    conflict_winner = fixed_prio ? PORT_CPU : other_port(last_grant);
    gnt             = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (conflict_winner == PORT_CPU) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // last_grant resets to DMA so the very first conflict goes to the CPU.
  // It is tracked in fixed-priority mode too, so the state is meaningful
  // whichever mode the instance is built in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= PORT_DMA;
    end else if (advance && (gnt != 2'b00)) begin
      last_grant <= gnt[1] ? PORT_DMA : PORT_CPU;
    end
  end

endmodule

// File: rtl/sram_2kx8_arbiter.sv
// ---------------------------------------------------------------------------
// sram_2kx8_arbiter
//   Two-port pipelined arbiter in front of the sram_2kx8 single-port block
//   RAM (bypass read mode). One SRAM access per cycle at most; each access
//   is acknowledged two cycles after acceptance on the port that issued it.
//
//   Cycle N   : accept  - grant one valid port, pX_ready pulses
//   Cycle N+1 : issue   - sram_ce/wre/ad/din driven from registers
//   Cycle N+2 : respond - pX_rsp_valid pulses, read data passed from sram_dout
//
//   Parameters:
//     ADDR_W      SRAM address width (2048 words by default)
//     DATA_W      SRAM data width
//     FIXED_PRIO  0 = round-robin, 1 = port 0 always wins a conflict
//
//   Ports:
//     clk, reset                  clock, asynchronous active-high reset
//     p0_valid/ready/we/addr/wdata  port 0 (CPU) request handshake
//     p0_rsp_valid, p0_rdata        port 0 completion pulse and read data
//     p1_*                          same set for port 1 (DMA)
//     sram_ce, sram_oce, sram_wre   SRAM controls (oce tied high)
//     sram_ad, sram_din             SRAM address and write data
//     sram_dout                     SRAM read data, valid the cycle after ce
// ---------------------------------------------------------------------------
module sram_2kx8_arbiter
  import sram_2kx8_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_rsp_valid,
  output logic [DATA_W-1:0] p0_rdata,

  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_rsp_valid,
  output logic [DATA_W-1:0] p1_rdata,

  output logic              sram_ce,
  output logic              sram_oce,
  output logic              sram_wre,
  output logic [ADDR_W-1:0] sram_ad,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout
);

  localparam logic FIXED_MODE = (FIXED_PRIO != 0);

  // Accept stage
  logic [1:0]        gnt;
  logic              accept;
  port_e             sel_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Issue stage bookkeeping (its valid bit is sram_ce itself)
  port_e             s1_port;
  logic              s1_we;

  // Response stage
  logic              s2_valid;
  port_e             s2_port;
  logic              s2_we;
  logic              p0_load;
  logic              p1_load;
  logic [DATA_W-1:0] p0_rdata_q;
  logic [DATA_W-1:0] p1_rdata_q;

  sram_2kx8_arbiter_rr_arb2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .req        ({p1_valid, p0_valid}),
    .fixed_prio (FIXED_MODE),
    .advance    (accept),
    .gnt        (gnt)
  );

  // The SRAM never stalls, so any grant is an accept.
  assign accept   = gnt[0] | gnt[1];
  assign p0_ready = p0_valid & gnt[0];
  assign p1_ready = p1_valid & gnt[1];

  // Bypass read mode: the output register enable is permanently on.
  assign sram_oce = 1'b1;

  always_comb begin
    sel_port  = gnt[1] ? PORT_DMA : PORT_CPU;
    sel_we    = p0_we;
    sel_addr  = p0_addr;
    sel_wdata = p0_wdata;
    if (sel_port == PORT_DMA) begin
      sel_we    = p1_we;
      sel_addr  = p1_addr;
      sel_wdata = p1_wdata;
    end
  end

  // Issue registers. When idle, ad/din keep their last value so the SRAM
  // pins stay quiet; only ce and wre fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sram_ce  <= 1'b0;
      sram_wre <= 1'b0;
      sram_ad  <= '0;
      sram_din <= '0;
      s1_port  <= PORT_CPU;
      s1_we    <= 1'b0;
    end else begin
      sram_ce  <= accept;
      sram_wre <= accept & sel_we;
      if (accept) begin
        sram_ad  <= sel_addr;
        sram_din <= sel_wdata;
        s1_port  <= sel_port;
        s1_we    <= sel_we;
      end
    end
  end

  // Response stage tracks which port owns the access the SRAM is
  // completing this cycle. An asynchronous reset wipes both stages, so no
  // in-flight access ever produces a response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_port  <= PORT_CPU;
      s2_we    <= 1'b0;
    end else begin
      s2_valid <= sram_ce;
      s2_port  <= s1_port;
      s2_we    <= s1_we;
    end
  end

  assign p0_rsp_valid = s2_valid & (s2_port == PORT_CPU);
  assign p1_rsp_valid = s2_valid & (s2_port == PORT_DMA);

  // sram_dout only becomes valid in the response cycle, so a read passes it
  // straight through to line up with rsp_valid; the copy captured at the end
  // of that cycle keeps rdata steady across writes and idle cycles.
  assign p0_load  = p0_rsp_valid & ~s2_we;
  assign p1_load  = p1_rsp_valid & ~s2_we;
  assign p0_rdata = p0_load ? sram_dout : p0_rdata_q;
  assign p1_rdata = p1_load ? sram_dout : p1_rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      p0_rdata_q <= p0_rdata;
      p1_rdata_q <= p1_rdata;
    end
  end

endmodule

// File: tb/tb_sram_2kx8_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_2kx8_arbiter
//   Two instances of the arbiter: index 0 round-robin, index 1 fixed
//   priority. Each drives its own behavioural SRAM. A reference model works
//   from the handshake rules: who should win, when each access completes,
//   and what memory holds when it does.
// ---------------------------------------------------------------------------
module tb_sram_2kx8_arbiter;

  localparam int AW = 11;
  localparam int DW = 8;

  typedef struct packed {
    logic          live;
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            due;
  } txn_t;

  logic clk = 1'b0;
  logic reset;

  logic          pv    [2][2];
  logic          pwe   [2][2];
  logic [AW-1:0] paddr [2][2];
  logic [DW-1:0] pwd   [2][2];
  logic          prdy  [2][2];
  logic          prsp  [2][2];
  logic [DW-1:0] prd   [2][2];

  logic          sce  [2];
  logic          soce [2];
  logic          swre [2];
  logic [AW-1:0] sad  [2];
  logic [DW-1:0] sdin [2];
  logic [DW-1:0] sdout[2];

  logic [DW-1:0] mem [2][2048];
  bit            mem_ready = 1'b0;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   last_g   [2];
  bit   prev_acc [2];
  bit   hold_we  [2];
  int   hold_ad  [2];
  int   hold_din [2];
  int   exp_rdata[2][2];
  bit   acc_flag [2][2];
  txn_t sb       [2][4];
  int   mem_m    [2][2048];

  always #5 clk = ~clk;

  sram_2kx8_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) dut_rr (
    .clk(clk), .reset(reset),
    .p0_valid(pv[0][0]), .p0_ready(prdy[0][0]), .p0_we(pwe[0][0]), .p0_addr(paddr[0][0]),
    .p0_wdata(pwd[0][0]), .p0_rsp_valid(prsp[0][0]), .p0_rdata(prd[0][0]),
    .p1_valid(pv[0][1]), .p1_ready(prdy[0][1]), .p1_we(pwe[0][1]), .p1_addr(paddr[0][1]),
    .p1_wdata(pwd[0][1]), .p1_rsp_valid(prsp[0][1]), .p1_rdata(prd[0][1]),
    .sram_ce(sce[0]), .sram_oce(soce[0]), .sram_wre(swre[0]), .sram_ad(sad[0]),
    .sram_din(sdin[0]), .sram_dout(sdout[0])
  );

  sram_2kx8_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) dut_fx (
    .clk(clk), .reset(reset),
    .p0_valid(pv[1][0]), .p0_ready(prdy[1][0]), .p0_we(pwe[1][0]), .p0_addr(paddr[1][0]),
    .p0_wdata(pwd[1][0]), .p0_rsp_valid(prsp[1][0]), .p0_rdata(prd[1][0]),
    .p1_valid(pv[1][1]), .p1_ready(prdy[1][1]), .p1_we(pwe[1][1]), .p1_addr(paddr[1][1]),
    .p1_wdata(pwd[1][1]), .p1_rsp_valid(prsp[1][1]), .p1_rdata(prd[1][1]),
    .sram_ce(sce[1]), .sram_oce(soce[1]), .sram_wre(swre[1]), .sram_ad(sad[1]),
    .sram_din(sdin[1]), .sram_dout(sdout[1])
  );

  function automatic int initVal(int i, int a);
    if (a == 'h123) return 'hA5;
    return ((a * 37 + i * 91) ^ (a >> 3)) & 'hFF;
  endfunction

  // Behavioural sram_2kx8: an enabled edge writes, or reads into dout.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 2; i++)
        for (int a = 0; a < 2048; a++)
          mem[i][a] = DW'(initVal(i, a));
      mem_ready = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      if (sce[i] === 1'b1) begin
        if (swre[i] === 1'b1) mem[i][sad[i]] = sdin[i];
        else                  sdout[i] <= mem[i][sad[i]];
      end
    end
  end

  task automatic checkOutput(string tag, int observed, int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic setReq(int i, int p, bit v, bit we, int addr, int wd);
    pv[i][p]    = v;
    pwe[i][p]   = we;
    paddr[i][p] = AW'(addr);
    pwd[i][p]   = DW'(wd);
  endtask

  task automatic clearAll();
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++)
        setReq(i, p, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      last_g[i]   = 1;
      prev_acc[i] = 1'b0;
      hold_we[i]  = 1'b0;
      hold_ad[i]  = 0;
      hold_din[i] = 0;
      for (int p = 0; p < 2; p++) begin
        exp_rdata[i][p] = 0;
        acc_flag[i][p]  = 1'b0;
      end
      for (int s = 0; s < 4; s++) sb[i][s] = '0;
    end
  endtask

  // One cycle of the reference for instance i, evaluated mid-cycle.
  task automatic modelCycle(int i);
    string    nm;
    int       slot;
    int       g;
    bit       v0, v1;
    bit [1:0] exp_rsp;
    txn_t     t;
    nm = (i == 0) ? "rr" : "fx";

    checkOutput($sformatf("%s.c%0d.sram_ce", nm, cyc), int'(sce[i]), int'(prev_acc[i]));
    checkOutput($sformatf("%s.c%0d.sram_oce", nm, cyc), int'(soce[i]), 1);
    checkOutput($sformatf("%s.c%0d.sram_wre", nm, cyc), int'(swre[i]),
                int'(prev_acc[i] & hold_we[i]));
    checkOutput($sformatf("%s.c%0d.sram_ad", nm, cyc), int'(sad[i]), hold_ad[i]);
    checkOutput($sformatf("%s.c%0d.sram_din", nm, cyc), int'(sdin[i]), hold_din[i]);

    exp_rsp = 2'b00;
    slot    = cyc % 4;
    t       = sb[i][slot];
    if (t.live && t.due == cyc) begin
      sb[i][slot].live = 1'b0;
      exp_rsp[t.port]  = 1'b1;
      if (t.we) mem_m[i][t.addr] = int'(t.wdata);
      else      exp_rdata[i][t.port] = mem_m[i][t.addr];
    end
    for (int p = 0; p < 2; p++) begin
      checkOutput($sformatf("%s.c%0d.p%0d_rsp_valid", nm, cyc, p), int'(prsp[i][p]), int'(exp_rsp[p]));
      checkOutput($sformatf("%s.c%0d.p%0d_rdata", nm, cyc, p), int'(prd[i][p]), exp_rdata[i][p]);
    end

    v0 = (pv[i][0] === 1'b1);
    v1 = (pv[i][1] === 1'b1);
    g  = -1;
    if (reset !== 1'b1) begin
      if (v0 && v1) g = (i == 1) ? 0 : (1 - last_g[i]);
      else if (v0)  g = 0;
      else if (v1)  g = 1;
    end
    for (int p = 0; p < 2; p++) begin
      checkOutput($sformatf("%s.c%0d.p%0d_ready", nm, cyc, p), int'(prdy[i][p]), int'(g == p));
      acc_flag[i][p] = (g == p);
    end

    prev_acc[i] = (g >= 0);
    if (g >= 0) begin
      last_g[i]   = g;
      hold_we[i]  = pwe[i][g];
      hold_ad[i]  = int'(paddr[i][g]);
      hold_din[i] = int'(pwd[i][g]);
      t.live  = 1'b1;
      t.port  = 1'(g);
      t.we    = pwe[i][g];
      t.addr  = paddr[i][g];
      t.wdata = pwd[i][g];
      t.due   = cyc + 2;
      sb[i][(cyc + 2) % 4] = t;
    end
  endtask

  task automatic step();
    @(negedge clk);
    modelCycle(0);
    modelCycle(1);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  function automatic int randAddr();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 2047));
    return int'($urandom_range(0, 7));
  endfunction

  // Requester behaviour: hold an unaccepted request (occasionally abandon
  // it), otherwise maybe start a new one.
  task automatic applyStimulus(int i);
    for (int p = 0; p < 2; p++) begin
      if (pv[i][p] && !acc_flag[i][p]) begin
        if ($urandom_range(0, 9) == 0) pv[i][p] = 1'b0;
      end else if ($urandom_range(0, 99) < 70) begin
        setReq(i, p, 1'b1, 1'($urandom_range(0, 1)), randAddr(), int'($urandom_range(0, 255)));
      end else begin
        pv[i][p] = 1'b0;
      end
    end
  endtask

  initial begin
    int save_ad;
    int save_din;
    reset = 1'b1;
    clearAll();
    modelReset();
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 2048; a++)
        mem_m[i][a] = initVal(i, a);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("reset.%0d.sram_ce", i), int'(sce[i]), 0);
      checkOutput($sformatf("reset.%0d.sram_oce", i), int'(soce[i]), 1);
      checkOutput($sformatf("reset.%0d.sram_ad", i), int'(sad[i]), 0);
      checkOutput($sformatf("reset.%0d.p0_rdata", i), int'(prd[i][0]), 0);
      checkOutput($sformatf("reset.%0d.p1_rsp_valid", i), int'(prsp[i][1]), 0);
    end
    reset = 1'b0;
    step();
    step();

    // Single read of a preloaded word.
    setReq(0, 0, 1'b1, 1'b0, 'h123, 0);
    #1 checkOutput("read.p0_ready", int'(prdy[0][0]), 1);
    step();
    clearAll();
    checkOutput("read.sram_ce", int'(sce[0]), 1);
    step();
    checkOutput("read.p0_rsp_valid", int'(prsp[0][0]), 1);
    checkOutput("read.p0_rdata", int'(prd[0][0]), 'hA5);
    step();
    step();

    // Write then read the top address back to back on port 1.
    setReq(0, 1, 1'b1, 1'b1, 'h7FF, 'h3C);
    #1 checkOutput("wr.p1_ready", int'(prdy[0][1]), 1);
    step();
    setReq(0, 1, 1'b1, 1'b0, 'h7FF, 0);
    #1 checkOutput("rd.p1_ready", int'(prdy[0][1]), 1);
    checkOutput("wr.sram_ad", int'(sad[0]), 'h7FF);
    checkOutput("wr.sram_wre", int'(swre[0]), 1);
    step();
    clearAll();
    checkOutput("wr.p1_rsp_valid", int'(prsp[0][1]), 1);
    step();
    checkOutput("rd.p1_rsp_valid", int'(prsp[0][1]), 1);
    checkOutput("rd.p1_rdata", int'(prd[0][1]), 'h3C);
    step();

    // Idle: SRAM pins quiet.
    step();
    save_ad  = int'(sad[0]);
    save_din = int'(sdin[0]);
    repeat (10) step();
    checkOutput("idle.sram_ce", int'(sce[0]), 0);
    checkOutput("idle.sram_ad", int'(sad[0]), save_ad);
    checkOutput("idle.sram_din", int'(sdin[0]), save_din);

    // Reset while a write is in the issue stage.
    setReq(0, 0, 1'b1, 1'b1, 'h055, 'h99);
    step();
    clearAll();
    checkOutput("rst.sram_ce_before", int'(sce[0]), 1);
    reset = 1'b1;
    modelReset();
    #1 checkOutput("rst.sram_ce_async", int'(sce[0]), 0);
    step();
    checkOutput("rst.p0_rsp_valid", int'(prsp[0][0]), 0);
    step();
    reset = 1'b0;

    // Continuous conflicts: RR alternates from P0; fixed starves P1 until P0 drops.
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++)
        setReq(i, p, 1'b1, 1'($urandom_range(0, 1)), randAddr(), int'($urandom_range(0, 255)));
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        for (int p = 0; p < 2; p++)
          if (acc_flag[0][p])
            setReq(0, p, 1'b1, 1'($urandom_range(0, 1)), randAddr(), int'($urandom_range(0, 255)));
        if (k >= 4) pv[1][0] = 1'b0;
        else if (acc_flag[1][0])
          setReq(1, 0, 1'b1, 1'($urandom_range(0, 1)), randAddr(), int'($urandom_range(0, 255)));
        if (acc_flag[1][1])
          setReq(1, 1, 1'b1, 1'($urandom_range(0, 1)), randAddr(), int'($urandom_range(0, 255)));
      end
      #1;
      checkOutput($sformatf("conf.rr.k%0d.p0_ready", k), int'(prdy[0][0]), int'(k % 2 == 0));
      checkOutput($sformatf("conf.rr.k%0d.p1_ready", k), int'(prdy[0][1]), int'(k % 2 == 1));
      checkOutput($sformatf("conf.fx.k%0d.p0_ready", k), int'(prdy[1][0]), int'(k < 4));
      checkOutput($sformatf("conf.fx.k%0d.p1_ready", k), int'(prdy[1][1]), int'(k >= 4));
      step();
    end
    clearAll();
    repeat (3) step();

    // Randomized traffic on both instances.
    for (int n = 0; n < 600; n++) begin
      applyStimulus(0);
      applyStimulus(1);
      step();
    end
    clearAll();
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] time limit");
  end

endmodule
